// File: rtl/eda_regional_max_reader.sv
// Regional-maximum result read-out: raster-scans the 1-bit mask and streams {mask,row,col,last}.
// Latency: start edge -> read issued the same cycle -> beat valid two edges after start.
// Backpressure: reads are throttled so FIFO occupancy plus the in-flight read never exceeds 2.

// Small synchronous FIFO with flush. DEPTH must be a power of two so the pointers wrap naturally.
module eda_rmr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload storage needs no reset; contents are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (count == '0);
endmodule

module eda_regional_max_reader #(
  parameter int M          = 6,
  parameter int N          = 6,
  parameter int I_WIDTH    = $clog2(M),
  parameter int J_WIDTH    = $clog2(N),
  parameter int ADDR_WIDTH = I_WIDTH + J_WIDTH,
  parameter int CNT_WIDTH  = $clog2(M*N+1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  clear,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_mask,
  output logic [I_WIDTH-1:0]    out_row,
  output logic [J_WIDTH-1:0]    out_col,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  max_count
);
  localparam int DW = 1 + I_WIDTH + J_WIDTH + 1;
  localparam int FIFO_DEPTH = 2;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(M*N);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [I_WIDTH-1:0] rd_i;
  logic [J_WIDTH-1:0] rd_j;
  logic               rd_last_addr;
  logic               rd_pend;
  logic [I_WIDTH-1:0] pend_row;
  logic [J_WIDTH-1:0] pend_col;
  logic               pend_last;
  logic [DW-1:0]      head;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;
  logic               fifo_empty;
  logic               pop;
  logic               can_issue;
  logic [2:0]         occ_next;
  logic               h_mask, h_last;
  logic [I_WIDTH-1:0] h_row;
  logic [J_WIDTH-1:0] h_col;

  assign rd_last_addr = (rd_i == I_WIDTH'(M-1)) && (rd_j == J_WIDTH'(N-1));
  assign mem_rd_addr  = {rd_i, rd_j};
  assign out_valid    = !fifo_empty;
  assign pop          = out_valid && out_ready;
  assign {h_mask, h_row, h_col, h_last} = head;

  // A new read may go out only if the slot it lands in is guaranteed free when the data returns.
  assign occ_next  = 3'(fifo_count) - 3'(pop) + 3'(rd_pend);
  assign can_issue = (occ_next < 3'(FIFO_DEPTH));

  // Beat fields are forced to zero while the stream is idle.
  assign out_mask = out_valid & h_mask;
  assign out_row  = out_valid ? h_row : '0;
  assign out_col  = out_valid ? h_col : '0;
  assign out_last = out_valid & h_last;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; clear dominates everything.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_READ;
      S_READ:  if (mem_rd_en && rd_last_addr) state_nxt = S_DRAIN;
      S_DRAIN: if (pop && h_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (clear) state_nxt = S_IDLE;
  end

  // State-decoded outputs.
  always_comb begin
    busy      = (state == S_READ) || (state == S_DRAIN);
    done      = (state == S_DONE);
    mem_rd_en = (state == S_READ) && can_issue && !clear;
  end

  // Raster read pointer: column inner, row outer; returns to (0,0) after the final address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_i <= '0;
      rd_j <= '0;
    end else if (clear || (state == S_IDLE && start)) begin
      rd_i <= '0;
      rd_j <= '0;
    end else if (mem_rd_en) begin
      if (rd_j == J_WIDTH'(N-1)) begin
        rd_j <= '0;
        rd_i <= rd_last_addr ? '0 : rd_i + I_WIDTH'(1);
      end else begin
        rd_j <= rd_j + J_WIDTH'(1);
      end
    end
  end

  // Coordinate tags ride along with the outstanding read until its data arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend   <= 1'b0;
      pend_row  <= '0;
      pend_col  <= '0;
      pend_last <= 1'b0;
    end else begin
      rd_pend <= mem_rd_en && !clear;
      if (mem_rd_en) begin
        pend_row  <= rd_i;
        pend_col  <= rd_j;
        pend_last <= rd_last_addr;
      end
    end
  end

  // Maxima counter: restarts on a new scan or clear, saturates at the pixel count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_count <= '0;
    end else if (clear || (state == S_IDLE && start)) begin
      max_count <= '0;
    end else if (pop && h_mask && (max_count != CNT_MAX)) begin
      max_count <= max_count + CNT_WIDTH'(1);
    end
  end

  eda_rmr_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (clear),
    .push      (rd_pend),
    .push_data ({mem_rd_data, pend_row, pend_col, pend_last}),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );
endmodule
